// File: rtl/das_sum_engine.sv
// Delay-and-sum engine: per output point, reads one delay per channel, fetches the
// addressed sample, accumulates, optionally averages, and streams the result out.
module das_sum_engine #(
    parameter int CH        = 8,
    parameter int SAMPLE_W  = 32,
    parameter int POINTS    = 768,
    parameter int DLY_AW    = 13,
    parameter int SMP_AW    = 13,
    parameter int SMP_DEPTH = 6144,
    parameter int RD_LAT    = 2,
    parameter int LOG2_CH   = $clog2(CH),
    parameter int SUM_W     = SAMPLE_W + LOG2_CH,
    parameter int IDX_W     = $clog2(POINTS)
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                start_i,
    input  logic                mode_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [DLY_AW-1:0]   dly_addr_o,
    output logic                dly_en_o,
    input  logic [SMP_AW-1:0]   dly_data_i,
    output logic [SMP_AW-1:0]   smp_addr_o,
    output logic                smp_en_o,
    input  logic [SAMPLE_W-1:0] smp_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [SUM_W-1:0]    out_data_o,
    output logic [IDX_W-1:0]    out_idx_o,
    output logic [2:0]          dbg_state_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_DLY = 3'd1;
    localparam logic [2:0] S_W_DLY  = 3'd2;
    localparam logic [2:0] S_RD_SMP = 3'd3;
    localparam logic [2:0] S_W_SMP  = 3'd4;
    localparam logic [2:0] S_OUT    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    // Handshake: a result transfers on a cycle where out_valid_o and out_ready_i are both
    // high; out_data_o/out_idx_o are registers that only change on entry to S_OUT.

    logic [2:0]              state_q, state_d;
    logic                    mode_q, mode_d;
    logic                    err_q, err_d;
    logic                    skip_q, skip_d;
    logic [IDX_W-1:0]        t_q, t_d;
    logic [LOG2_CH-1:0]      c_q, c_d;
    logic [2:0]              w_q, w_d;
    logic signed [SUM_W-1:0] acc_q, acc_d;
    logic [DLY_AW-1:0]       dly_addr_q, dly_addr_d;
    logic [SMP_AW-1:0]       smp_addr_q, smp_addr_d;
    logic [SUM_W-1:0]        out_data_q, out_data_d;
    logic [IDX_W-1:0]        out_idx_q, out_idx_d;

    logic                    w_last;
    logic                    oor;
    logic signed [SUM_W-1:0] contrib;
    logic signed [SUM_W-1:0] acc_sum;

    always_comb begin
        w_last  = (w_q == 3'(RD_LAT - 1));
        oor     = (32'(dly_data_i) >= SMP_DEPTH);
        contrib = skip_q ? '0 : {{LOG2_CH{smp_data_i[SAMPLE_W-1]}}, smp_data_i};
        acc_sum = acc_q + contrib;

        state_d    = state_q;
        mode_d     = mode_q;
        err_d      = err_q;
        skip_d     = skip_q;
        t_d        = t_q;
        c_d        = c_q;
        w_d        = w_q;
        acc_d      = acc_q;
        dly_addr_d = dly_addr_q;
        smp_addr_d = smp_addr_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d  = mode_i;
                    err_d   = 1'b0;
                    t_d     = '0;
                    c_d     = '0;
                    acc_d   = '0;
                    state_d = S_RD_DLY;
                end
            end
            S_RD_DLY: begin
                w_d     = '0;
                state_d = S_W_DLY;
            end
            S_W_DLY: begin
                if (w_last) begin
                    smp_addr_d = dly_data_i;
                    skip_d     = oor;
                    state_d    = S_RD_SMP;
                end else begin
                    w_d = w_q + 3'd1;
                end
            end
            S_RD_SMP: begin
                if (skip_q) err_d = 1'b1;
                w_d     = '0;
                state_d = S_W_SMP;
            end
            S_W_SMP: begin
                if (w_last) begin
                    acc_d = acc_sum;
                    if (c_q != LOG2_CH'(CH - 1)) begin
                        c_d     = c_q + LOG2_CH'(1);
                        state_d = S_RD_DLY;
                    end else begin
                        out_data_d = mode_q ? SUM_W'(acc_sum >>> LOG2_CH) : acc_sum;
                        out_idx_d  = t_q;
                        state_d    = S_OUT;
                    end
                end else begin
                    w_d = w_q + 3'd1;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    acc_d = '0;
                    c_d   = '0;
                    if (t_q != IDX_W'(POINTS - 1)) begin
                        t_d     = t_q + IDX_W'(1);
                        state_d = S_RD_DLY;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Delay address is registered on entry so it is valid for the whole RD_DLY cycle.
        if (state_d == S_RD_DLY && state_q != S_RD_DLY) begin
            dly_addr_d = DLY_AW'(c_d) * DLY_AW'(POINTS) + DLY_AW'(t_d);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            err_q      <= 1'b0;
            skip_q     <= 1'b0;
            t_q        <= '0;
            c_q        <= '0;
            w_q        <= '0;
            acc_q      <= '0;
            dly_addr_q <= '0;
            smp_addr_q <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            skip_q     <= skip_d;
            t_q        <= t_d;
            c_q        <= c_d;
            w_q        <= w_d;
            acc_q      <= acc_d;
            dly_addr_q <= dly_addr_d;
            smp_addr_q <= smp_addr_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
    assign dly_addr_o  = dly_addr_q;
    assign dly_en_o    = (state_q == S_RD_DLY);
    assign smp_addr_o  = smp_addr_q;
    assign smp_en_o    = (state_q == S_RD_SMP) && !skip_q;
    assign out_valid_o = (state_q == S_OUT);
    assign out_data_o  = out_data_q;
    assign out_idx_o   = out_idx_q;
    assign dbg_state_o = state_q;

endmodule
